// File: rtl/force_cache_responder.sv
// Per-cell force cache read responder: holds lr/sr/bf force banks for one cell
// and serves summation reads with a fixed two-cycle latency.
module force_cache_responder #(
  parameter int unsigned DATA_WIDTH               = 32,
  parameter int unsigned CELL_DEPTH               = 128,
  parameter int unsigned ADDR_WIDTH               = 7,
  parameter int unsigned PARTICLE_GLOBAL_ID_WIDTH = 15
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  input  logic [1:0]                          wr_sel,
  input  logic [ADDR_WIDTH-1:0]               wr_addr,
  input  logic [3*DATA_WIDTH-1:0]             wr_data,
  input  logic                                pc_valid,
  input  logic [ADDR_WIDTH:0]                 pc_count,
  input  logic                                sr_done,
  output logic                                cell_done,
  input  logic                                rd_en,
  input  logic [PARTICLE_GLOBAL_ID_WIDTH-1:0] rd_addr,
  output logic [3*DATA_WIDTH-1:0]             force_lr_out,
  output logic [3*DATA_WIDTH-1:0]             force_sr_out,
  output logic [3*DATA_WIDTH-1:0]             force_bf_out,
  output logic                                valid_out,
  output logic [PARTICLE_GLOBAL_ID_WIDTH-1:0] gid_out,
  output logic                                err
);
  localparam int unsigned LW = 3 * DATA_WIDTH;
  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned GW = PARTICLE_GLOBAL_ID_WIDTH;

  typedef enum logic [1:0] {S_FILL, S_READY, S_DRAIN} state_t;
  typedef enum logic [1:0] {RK_ZERO, RK_COUNT, RK_SLOT} rkind_t;

  logic [LW-1:0] mem_lr [CELL_DEPTH];
  logic [LW-1:0] mem_sr [CELL_DEPTH];
  logic [LW-1:0] mem_bf [CELL_DEPTH];

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rkind_t          kind_c;
  logic            wr_en_c, err_set_c, cd_c, pc_over_c;
  logic [CW-1:0]   pc_sat_c;

  logic            p1_valid, p2_valid;
  rkind_t          p1_kind, p2_kind;
  logic [GW-1:0]   p1_gid, p2_gid;
  logic [CW-1:0]   p1_cnt, p2_cnt;
  logic [ADDR_WIDTH-1:0] p1_slot;
  logic [LW-1:0]   q_lr, q_sr, q_bf;

  // Next-state, count update, read classification and error detection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_c    = RK_ZERO;
    wr_en_c   = 1'b0;
    err_set_c = 1'b0;
    cd_c      = 1'b0;
    pc_over_c = (pc_count > CW'(CELL_DEPTH));
    pc_sat_c  = pc_over_c ? CW'(CELL_DEPTH) : pc_count;
    case (state_q)
      S_FILL: begin
        wr_en_c = wr_valid && (wr_sel != 2'd3);
        if (pc_valid) begin
          cnt_d = pc_sat_c;
          if (pc_over_c) err_set_c = 1'b1;
        end
        if (sr_done) begin
          state_d = S_READY;
          cd_c    = 1'b1;
        end
        if (rd_en) err_set_c = 1'b1;
      end
      S_READY, S_DRAIN: begin
        if ((wr_valid && (wr_sel != 2'd3)) || pc_valid || sr_done) err_set_c = 1'b1;
        if (rd_en) begin
          state_d = S_DRAIN;
          if (rd_addr == '0) begin
            kind_c = RK_COUNT;
          end else if (rd_addr <= GW'(cnt_q)) begin
            kind_c = RK_SLOT;
          end else begin
            err_set_c = 1'b1;
          end
          // The read of the last slot (or the count query of an empty cell) closes the cell
          if (rd_addr == GW'(cnt_q)) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // Force banks: writes only in FILL, synchronous read one cycle after the request
  always_ff @(posedge clk) begin
    if (wr_en_c && wr_sel == 2'd0) mem_lr[wr_addr] <= wr_data;
    if (wr_en_c && wr_sel == 2'd1) mem_sr[wr_addr] <= wr_data;
    if (wr_en_c && wr_sel == 2'd2) mem_bf[wr_addr] <= wr_data;
    q_lr <= mem_lr[p1_slot];
    q_sr <= mem_sr[p1_slot];
    q_bf <= mem_bf[p1_slot];
  end

  // State, flags and the two-stage read pipeline
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_FILL;
      cnt_q        <= '0;
      err          <= 1'b0;
      cell_done    <= 1'b0;
      p1_valid     <= 1'b0;
      p1_kind      <= RK_ZERO;
      p1_gid       <= '0;
      p1_cnt       <= '0;
      p1_slot      <= '0;
      p2_valid     <= 1'b0;
      p2_kind      <= RK_ZERO;
      p2_gid       <= '0;
      p2_cnt       <= '0;
      valid_out    <= 1'b0;
      gid_out      <= '0;
      force_lr_out <= '0;
      force_sr_out <= '0;
      force_bf_out <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cell_done <= cd_c;
      if (err_set_c) err <= 1'b1;
      p1_valid  <= rd_en;
      p1_kind   <= kind_c;
      p1_gid    <= rd_addr;
      p1_cnt    <= cnt_q;
      p1_slot   <= ADDR_WIDTH'(rd_addr - GW'(1));
      p2_valid  <= p1_valid;
      p2_kind   <= p1_kind;
      p2_gid    <= p1_gid;
      p2_cnt    <= p1_cnt;
      valid_out <= p2_valid;
      gid_out   <= p2_gid;
      case (p2_kind)
        RK_COUNT: begin
          force_lr_out <= '0;
          force_sr_out <= '0;
          force_bf_out <= LW'(p2_cnt);
        end
        RK_SLOT: begin
          force_lr_out <= q_lr;
          force_sr_out <= q_sr;
          force_bf_out <= q_bf;
        end
        default: begin
          force_lr_out <= '0;
          force_sr_out <= '0;
          force_bf_out <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_force_cache_responder.sv
// Self-checking bench for force_cache_responder: directed scenarios plus a
// randomized run, all compared against a queue-based behavioural model.
module tb_force_cache_responder;
  localparam int DW = 32;
  localparam int CD = 128;
  localparam int AW = 7;
  localparam int GW = 15;
  localparam int LW = 3 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_data;
  logic          pc_valid;
  logic [AW:0]   pc_count;
  logic          sr_done;
  logic          cell_done;
  logic          rd_en;
  logic [GW-1:0] rd_addr;
  logic [LW-1:0] force_lr_out, force_sr_out, force_bf_out;
  logic          valid_out;
  logic [GW-1:0] gid_out;
  logic          err;

  force_cache_responder #(
    .DATA_WIDTH(DW), .CELL_DEPTH(CD), .ADDR_WIDTH(AW), .PARTICLE_GLOBAL_ID_WIDTH(GW)
  ) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .pc_valid(pc_valid), .pc_count(pc_count), .sr_done(sr_done),
    .cell_done(cell_done), .rd_en(rd_en), .rd_addr(rd_addr),
    .force_lr_out(force_lr_out), .force_sr_out(force_sr_out), .force_bf_out(force_bf_out),
    .valid_out(valid_out), .gid_out(gid_out), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [GW-1:0] gid;
    logic [LW-1:0] lr;
    logic [LW-1:0] sr;
    logic [LW-1:0] bf;
  } rsp_t;
  typedef struct {
    int   due;
    rsp_t r;
  } pend_t;

  // Behavioural model: cell is either filling or being served
  logic [LW-1:0] m_lr [CD];
  logic [LW-1:0] m_sr [CD];
  logic [LW-1:0] m_bf [CD];
  int            m_cnt;
  bit            m_ready;
  bit            m_err;
  bit            exp_cd;
  rsp_t          exp_rsp;
  pend_t         exp_q[$];
  int            cycle;
  int            tests;
  int            failed;

  logic [2+$bits(rsp_t)-1:0] obs, exp_all;
  assign obs = {cell_done, err, valid_out, gid_out, force_lr_out, force_sr_out, force_bf_out};

  task automatic idle();
    wr_valid = 1'b0; wr_sel = 2'd0; wr_addr = '0; wr_data = '0;
    pc_valid = 1'b0; pc_count = '0; sr_done = 1'b0;
    rd_en = 1'b0; rd_addr = '0;
  endtask

  function automatic logic [LW-1:0] rnd_lane();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Advance one clock, then update the model from the inputs sampled at that edge
  task automatic cyc();
    pend_t p;
    @(posedge clk);
    cycle++;
    exp_cd = 1'b0;
    if (!rst) begin
      m_cnt = 0; m_ready = 1'b0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      if (rd_en) begin
        p.due = cycle + 2;
        p.r = '0;
        p.r.v = 1'b1;
        p.r.gid = rd_addr;
        if (!m_ready) m_err = 1'b1;
        else if (rd_addr == 0) p.r.bf = LW'(m_cnt);
        else if (int'(rd_addr) <= m_cnt) begin
          p.r.lr = m_lr[int'(rd_addr) - 1];
          p.r.sr = m_sr[int'(rd_addr) - 1];
          p.r.bf = m_bf[int'(rd_addr) - 1];
        end else m_err = 1'b1;
        exp_q.push_back(p);
      end
      if (!m_ready) begin
        if (wr_valid && wr_sel == 2'd0) m_lr[wr_addr] = wr_data;
        if (wr_valid && wr_sel == 2'd1) m_sr[wr_addr] = wr_data;
        if (wr_valid && wr_sel == 2'd2) m_bf[wr_addr] = wr_data;
        if (pc_valid) begin
          m_cnt = (int'(pc_count) > CD) ? CD : int'(pc_count);
          if (int'(pc_count) > CD) m_err = 1'b1;
        end
        if (sr_done) begin m_ready = 1'b1; exp_cd = 1'b1; end
      end else begin
        if ((wr_valid && wr_sel != 2'd3) || pc_valid || sr_done) m_err = 1'b1;
        if (rd_en && int'(rd_addr) == m_cnt) begin m_ready = 1'b0; m_cnt = 0; end
      end
    end
    exp_rsp = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cycle) exp_rsp = exp_q.pop_front().r;
    exp_all = {exp_cd, m_err, exp_rsp};
    #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b0; cyc(); cyc(); rst = 1'b1;
  endtask

  // Legal fill of slots 0..n-1 in all three banks, count load, sr_done
  task automatic fill_cell(input int n);
    idle(); pc_valid = 1'b1; pc_count = (AW+1)'(n); cyc();
    for (int s = 0; s < n; s++)
      for (int b = 0; b < 3; b++) begin
        idle(); wr_valid = 1'b1; wr_sel = 2'(b); wr_addr = AW'(s); wr_data = rnd_lane(); cyc();
      end
    idle(); sr_done = 1'b1; cyc(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++;
      if (obs !== '0) begin failed++; $display("FAIL reset cyc=%0d got=%h want=0", cycle, obs); end
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    fill_cell(3);
    tests++;
    if (cell_done !== 1'b1) begin failed++; $display("FAIL basic_cell_done_hi got=%b want=1", cell_done); end
    cyc();
    tests++;
    if (cell_done !== 1'b0) begin failed++; $display("FAIL basic_cell_done_lo got=%b want=0", cell_done); end
    for (int a = 0; a <= 3; a++) begin
      idle(); rd_en = 1'b1; rd_addr = GW'(a);
      for (int k = 0; k < 3; k++) begin
        cyc(); idle();
        tests++;
        if (obs !== exp_all) begin failed++; $display("FAIL basic_read a=%0d cyc=%0d got=%h want=%h", a, cycle, obs, exp_all); end
      end
    end
    // A legal write now must not flag an error: cell is back in FILL
    idle(); wr_valid = 1'b1; wr_sel = 2'd0; wr_addr = AW'(5); wr_data = rnd_lane(); cyc(); idle();
    tests++;
    if (err !== 1'b0) begin failed++; $display("FAIL basic_back_to_fill err got=%b want=0", err); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    nvalid = 0;
    fill_cell(4);
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 4) begin rd_en = 1'b1; rd_addr = GW'(i + 1); end
      cyc();
      if (valid_out === 1'b1) nvalid++;
      tests++;
      if (obs !== exp_all) begin failed++; $display("FAIL b2b cyc=%0d got=%h want=%h", cycle, obs, exp_all); end
    end
    tests++;
    if (nvalid != 4) begin failed++; $display("FAIL b2b_valid_count got=%0d want=4", nvalid); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    fill_cell(2);
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i == 0) begin rd_en = 1'b1; rd_addr = GW'(5); end
      if (i == 1) begin rd_en = 1'b1; rd_addr = GW'(1); end
      if (i == 2) begin rd_en = 1'b1; rd_addr = GW'(2); end
      cyc();
      tests++;
      if (obs !== exp_all) begin failed++; $display("FAIL oor cyc=%0d got=%h want=%h", cycle, obs, exp_all); end
    end
    tests++;
    if (err !== 1'b1) begin failed++; $display("FAIL oor_err_sticky got=%b want=1", err); end
  endtask

  task automatic test_protocol();
    do_reset();
    fill_cell(2);
    for (int i = 0; i < 12; i++) begin
      idle();
      if (i == 0) begin rd_en = 1'b1; rd_addr = GW'(1); end
      if (i == 1) begin wr_valid = 1'b1; wr_sel = 2'd0; wr_addr = AW'(0); wr_data = rnd_lane(); end
      if (i == 2) begin rd_en = 1'b1; rd_addr = GW'(1); end
      if (i == 3) begin rd_en = 1'b1; rd_addr = GW'(2); end
      if (i == 7) begin rd_en = 1'b1; rd_addr = GW'(1); end
      cyc();
      tests++;
      if (obs !== exp_all) begin failed++; $display("FAIL protocol cyc=%0d got=%h want=%h", cycle, obs, exp_all); end
    end
  endtask

  task automatic test_empty();
    do_reset();
    fill_cell(0);
    tests++;
    if (obs !== exp_all) begin failed++; $display("FAIL empty_cell_done got=%h want=%h", obs, exp_all); end
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i == 0) begin rd_en = 1'b1; rd_addr = '0; end
      if (i == 3) begin wr_valid = 1'b1; wr_sel = 2'd1; wr_addr = AW'(9); wr_data = rnd_lane(); end
      cyc();
      tests++;
      if (obs !== exp_all) begin failed++; $display("FAIL empty cyc=%0d got=%h want=%h", cycle, obs, exp_all); end
    end
  endtask

  task automatic test_reset_mid_drain();
    fill_cell(3);
    idle(); rd_en = 1'b1; rd_addr = GW'(1); cyc();
    idle(); rst = 1'b0; cyc(); rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i == 3) sr_done = 1'b1;
      if (i == 5) begin rd_en = 1'b1; rd_addr = '0; end
      cyc();
      tests++;
      if (obs !== exp_all) begin failed++; $display("FAIL rst_mid_drain cyc=%0d got=%h want=%h", cycle, obs, exp_all); end
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int s = 0; s < CD; s++)
      for (int b = 0; b < 3; b++) begin
        idle(); wr_valid = 1'b1; wr_sel = 2'(b); wr_addr = AW'(s); wr_data = rnd_lane(); cyc();
      end
    for (int i = 0; i < 1500; i++) begin
      idle();
      r = int'($urandom_range(0, 15));
      if (!m_ready) begin
        if (r < 9) begin
          wr_valid = 1'b1; wr_sel = 2'($urandom_range(0, 3));
          wr_addr = AW'($urandom_range(0, CD - 1)); wr_data = rnd_lane();
        end else if (r < 12) begin
          pc_valid = 1'b1;
          pc_count = ($urandom_range(0, 4) == 0) ? (AW+1)'($urandom_range(0, 255))
                                                 : (AW+1)'($urandom_range(0, 6));
          if ($urandom_range(0, 1) == 1) sr_done = 1'b1;
        end else if (r < 14) begin
          sr_done = 1'b1;
        end else if (r == 14) begin
          rd_en = 1'b1; rd_addr = GW'($urandom_range(0, 20));
        end
      end else begin
        if (r < 12) begin
          rd_en = 1'b1;
          rd_addr = ($urandom_range(0, 3) == 0) ? GW'(m_cnt) : GW'($urandom_range(0, m_cnt + 2));
        end else if (r == 12) begin
          wr_valid = 1'b1; wr_sel = 2'($urandom_range(0, 3));
          wr_addr = AW'($urandom_range(0, CD - 1)); wr_data = rnd_lane();
        end else if (r == 13) begin
          pc_valid = 1'b1; pc_count = (AW+1)'($urandom_range(0, 6));
        end else if (r == 14) begin
          sr_done = 1'b1;
        end
      end
      cyc();
      tests++;
      if (obs !== exp_all) begin failed++; $display("FAIL random cyc=%0d got=%h want=%h", cycle, obs, exp_all); end
    end
  endtask

  initial begin
    cycle = 0; tests = 0; failed = 0;
    m_cnt = 0; m_ready = 1'b0; m_err = 1'b0; exp_cd = 1'b0;
    exp_rsp = '0; exp_all = '0;
    rst = 1'b0;
    idle();
    test_reset();
    test_basic();
    test_back_to_back();
    test_out_of_range();
    test_protocol();
    test_empty();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/force_cache_responder.md
# force_cache_responder

Per-cell force cache read responder: the serving end of the summation read protocol. It stores the long-range, short-range and bonded force words for the particles of one cell, and raises `cell_done` once short-range evaluation for the cell has finished. It answers the summation logic's per-cell read request with all three force lanes plus a valid strobe, at a fixed latency. One instance sits per cell, between the force pipelines and the summation logic.

## Interface
- `DATA_WIDTH`, 32, width of one force component (fp32 bit pattern, stored opaquely).
- `CELL_DEPTH`, 128, maximum particles per cell.
- `ADDR_WIDTH`, 7, log2(`CELL_DEPTH`).
- `PARTICLE_GLOBAL_ID_WIDTH`, 15, width of the read address and echoed gid.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-low reset.
- `wr_valid` in 1: force write strobe from a pipeline.
- `wr_sel` in 2: target bank; 0 = lr, 1 = sr, 2 = bf, 3 = discard.
- `wr_addr` in `ADDR_WIDTH`: particle slot.
- `wr_data` in 3*`DATA_WIDTH`: {z, y, x} force.
- `pc_valid` in 1: particle-count load strobe.
- `pc_count` in `ADDR_WIDTH`+1: particles in this cell, 0..`CELL_DEPTH`.
- `sr_done` in 1: short-range evaluation of this cell complete (single-cycle pulse).
- `cell_done` out 1: one-cycle pulse to the scoreboard.
- `rd_en` in 1: this cell's bit of the summation read request.
- `rd_addr` in `PARTICLE_GLOBAL_ID_WIDTH`: 0 = count query; k = particle slot k-1.
- `force_lr_out`, `force_sr_out`, `force_bf_out` out 3*`DATA_WIDTH` each: read data.
- `valid_out` out 1: read data valid.
- `gid_out` out `PARTICLE_GLOBAL_ID_WIDTH`: `rd_addr` echoed, aligned with `valid_out`.
- `err` out 1: sticky protocol-error flag.

## Operation
- Three banks of `CELL_DEPTH` x 3*`DATA_WIDTH` simple dual-port RAM, with a synchronous read. Plus a count register `cnt`.
- FSM states: FILL, READY, DRAIN. Reset enters FILL with `cnt` = 0.
- **FILL**
  - `wr_valid` writes `wr_data` into bank `wr_sel` at `wr_addr`. Writes are last-writer-wins.
  - `pc_valid` loads `cnt` from `pc_count`. A value above `CELL_DEPTH` saturates to `CELL_DEPTH` and sets `err`.
  - `sr_done` → READY, and `cell_done` pulses on the next cycle.
- **READY**: first accepted `rd_en` → DRAIN.
- **DRAIN / READY read service**
  - `rd_addr` = 0: lr = sr = 0; bf = `cnt` zero-extended into the low bits of the x lane, y = z = 0.
  - 1 ≤ `rd_addr` ≤ `cnt`: return all three banks at slot `rd_addr`-1.
  - `rd_addr` > `cnt`: return all zeros, `valid_out` still asserted, `err` set.
  - Accepting a read with `rd_addr` == `cnt` (including `cnt` = 0 with `rd_addr` = 0) → FILL and clears `cnt`. RAM contents are not cleared.
- **Illegal events**: each sets `err`, and the event is otherwise dropped.
  - `wr_valid` with `wr_sel` ≠ 3 outside FILL.
  - `pc_valid` outside FILL.
  - `sr_done` outside FILL.
  - `rd_en` in FILL. This read still returns zeros with `valid_out` so the requester never hangs.
- **Simultaneous events**
  - `pc_valid` and `sr_done` in the same cycle: the load takes effect, and the transition uses the new `cnt`.
  - `wr_valid` and `sr_done` in the same cycle: the write commits.
  - Write and read to the same slot cannot collide, because they are legal in disjoint states.
- `err` clears only on reset.

## Timing
- Reset values: all outputs 0; FSM = FILL; `cnt` = 0.
- Read latency is 2 cycles. `rd_en` sampled at edge T → `valid_out`, data and `gid_out` registered at edge T+2, held for one cycle.
- `rd_en` may be asserted every cycle (fully pipelined). Read requests have no backpressure.
- `cell_done` goes high one cycle after the `sr_done` edge, for exactly one cycle.
- A write at edge T is readable by a read sampled at T+1 or later.
- Reset asserted mid-DRAIN:
  - In-flight reads are squashed; no `valid_out` follows reset.
  - FSM returns to FILL.

## Test plan
- **Basic fill and drain**: reset; `pc_count`=3; write slots 0..2 in all banks with distinct patterns; pulse `sr_done`.
  - `cell_done` is high exactly one cycle after `sr_done`.
  - Reads of addr 0..3 return count 3 in bf.x, then the slot patterns, each at +2 cycles with `gid_out` = addr.
  - FSM is back in FILL after addr 3.
- **Back-to-back reads**: `rd_en` on 4 consecutive cycles → 4 consecutive `valid_out` cycles, data in order, no bubbles.
- **Out-of-range read**: `cnt`=2, read addr 5 → all-zero data, `valid_out`=1, `err`=1 and stays 1.
- **Protocol violations**:
  - A write during DRAIN is dropped; a later re-read of that slot returns the old data, and `err`=1.
  - A read in FILL returns zeros with `valid_out`.
- **Empty cell**: `cnt`=0, `sr_done` → `cell_done`; read addr 0 returns 0 and returns the FSM to FILL.
- **Reset mid-drain**: `rst`=0 one cycle after `rd_en` → no `valid_out`, all outputs 0, FSM = FILL, `cnt` = 0.
